// File: rtl/mult_seq_pkg.sv
// Shared types, widths and helpers for the sequenced multiplier.
package mult_seq_pkg;

    localparam int A_W = 16;
    localparam int C_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One-hot mask of the least significant set bit (zero in, zero out).
    function automatic logic [15:0] lowest_set(input logic [15:0] x);
        return x & (~x + 16'd1);
    endfunction

endpackage

// File: rtl/two_bit_multiplier.sv
// Combinational a*b for a multiplier b holding at most two set bits; any set
// bits beyond the lowest two are ignored. Output is zero while vld is low.
module two_bit_multiplier
    import mult_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           vld,
    input  logic [A_W-1:0] a,
    input  logic [N-1:0]   b,
    output logic [C_W-1:0] c,
    output logic           result_vld
);

    int used;

    always_comb begin
        c    = '0;
        used = 0;
        for (int i = 0; i < N; i++) begin
            if (vld && b[i] && used < 2) begin
                c    = c + (C_W'(a) << i);
                used = used + 1;
            end
        end
    end

    assign result_vld = vld;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer building a 16 x N multiply from two-set-bit partial products.
// Optional MULT_SEQ_PERF_EN adds the op_cycles RUN-cycle counter output.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [A_W-1:0] in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [C_W-1:0] out_c,
    output logic           busy
`ifdef MULT_SEQ_PERF_EN
    ,
    output logic [4:0]     op_cycles
`endif
);

    state_e         state, state_nxt;
    logic [A_W-1:0] a_q;
    logic [N-1:0]   rem_b, chunk, rem_nxt;
    logic [C_W-1:0] acc, prod, acc_nxt;
    logic [15:0]    rem16, m1, m2;
    logic           accept, mul_vld, mul_vld_unused;

    // Peel the lowest two set bits off the remaining multiplier.
    assign rem16   = 16'(rem_b);
    assign m1      = lowest_set(rem16);
    assign m2      = lowest_set(rem16 & ~m1);
    assign chunk   = N'(m1 | m2);
    assign rem_nxt = rem_b & ~chunk;
    assign acc_nxt = acc + prod;

    assign mul_vld = (state == RUN);
    assign accept  = in_vld & in_rdy;
    assign busy    = (state != IDLE);

    two_bit_multiplier #(.N(N)) u_mul (
        .vld        (mul_vld),
        .a          (a_q),
        .b          (chunk),
        .c          (prod),
        .result_vld (mul_vld_unused)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (rem_nxt == '0) state_nxt = DONE;
            DONE:    if (out_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            in_rdy  <= 1'b0;
            a_q     <= '0;
            rem_b   <= '0;
            acc     <= '0;
            out_vld <= 1'b0;
            out_c   <= '0;
        end else begin
            state  <= state_nxt;
            // Registered so it rises on the first edge after reset release.
            in_rdy <= (state_nxt == IDLE);
            case (state)
                IDLE: if (accept) begin
                    a_q   <= in_a;
                    rem_b <= in_b;
                    acc   <= '0;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    rem_b <= rem_nxt;
                    if (rem_nxt == '0) begin
                        out_c   <= acc_nxt;
                        out_vld <= 1'b1;
                    end
                end
                DONE: if (out_rdy) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef MULT_SEQ_PERF_EN
    logic [4:0] cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            op_cycles <= '0;
        end else if (state == IDLE && accept) begin
            cyc_cnt <= '0;
        end else if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 5'd1;
            if (rem_nxt == '0) op_cycles <= cyc_cnt + 5'd1;
        end
    end
`endif

endmodule
